// File: rtl/pipe_ifq.sv
// pipe_ifq: instruction fetch queue between IF and ID.
// A small circular FIFO of {pc4, ins} pairs so fetch can keep running while
// decode stalls. f_ready doubles as the PC write enable; flush discards all
// queued instructions on a redirect.
// Optional build macro PIPE_IFQ_PERF_EN adds stall_cnt / flush_cnt counters.
module pipe_ifq #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          f_valid,
  input  logic [31:0]   f_pc4,
  input  logic [31:0]   f_ins,
  output logic          f_ready,
  input  logic          flush,
  input  logic          d_ready,
  output logic          d_valid,
  output logic [31:0]   d_pc4,
  output logic [31:0]   d_ins,
`ifdef PIPE_IFQ_PERF_EN
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt,
`endif
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wp_reg, wp_next;
  logic [AW-1:0] rp_reg, rp_next;
  logic [AW:0]   cnt_reg, cnt_next;
  logic          push, pop;
  logic [63:0]   head;

  // Handshake and head decode; reset forces every output to its idle value.
  always_comb begin
    f_ready = ~reset & (cnt_reg != FULL_CNT);
    d_valid = ~reset & (cnt_reg != '0);
    push    = f_valid & f_ready & ~flush;
    pop     = d_valid & d_ready & ~flush;
    head    = mem[rp_reg];
    d_pc4   = d_valid ? head[63:32] : 32'h0;
    d_ins   = d_valid ? head[31:0]  : 32'h0;
    count   = reset ? '0 : cnt_reg;
  end

  // Pointer and occupancy next-state; flush wins over push/pop.
  always_comb begin
    wp_next  = wp_reg;
    rp_next  = rp_reg;
    cnt_next = cnt_reg;
    if (flush) begin
      wp_next  = '0;
      rp_next  = '0;
      cnt_next = '0;
    end else begin
      if (push) wp_next = wp_reg + 1'b1;
      if (pop)  rp_next = rp_reg + 1'b1;
      case ({push, pop})
        2'b10:   cnt_next = cnt_reg + 1'b1;
        2'b01:   cnt_next = cnt_reg - 1'b1;
        default: cnt_next = cnt_reg;
      endcase
    end
  end

  // Pointer/occupancy registers; reset overrides flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      wp_reg  <= '0;
      rp_reg  <= '0;
      cnt_reg <= '0;
    end else begin
      wp_reg  <= wp_next;
      rp_reg  <= rp_next;
      cnt_reg <= cnt_next;
    end
  end

  // Storage: each entry captures the fetched pair when the write pointer selects it.
  // Contents need no reset; the occupancy count qualifies every read.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clock) begin
      if (push && (wp_reg == AW'(gi))) begin
        mem[gi] <= {f_pc4, f_ins};
      end
    end
  end

`ifdef PIPE_IFQ_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  // Performance counters: fetch stalls on a full queue, and redirects seen.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_reg <= 32'h0;
      flush_cnt_reg <= 32'h0;
    end else begin
      if (f_valid && !f_ready) stall_cnt_reg <= stall_cnt_reg + 32'h1;
      if (flush)               flush_cnt_reg <= flush_cnt_reg + 32'h1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule
